// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Operand/result handshake bundle between the operand source and the
// nibble-serial add/subtract controller.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  // Operand source side
  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, cout, overflow
  );

  // Controller side
  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial add/subtract controller. Steps a W-bit operation through an
// external 4-bit add-only slice, LSB nibble first, and assembles the result.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; slice inputs forced to 0, results held
// RUN    | one nibble per cycle through the slice, idx = current nibble
// DONE   | one-cycle done pulse, results valid; returns to IDLE
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_addsub_ctrl_if.slave    bus,
  output logic [3:0]                    alu_a_o,
  output logic [3:0]                    alu_b_o,
  output logic                          alu_cin_o,
  input  logic [3:0]                    alu_s_i,
  input  logic                          alu_cout_i
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [W-1:0]  opa_q,    opa_d;
  logic [W-1:0]  opb_q,    opb_d;
  logic          carry_q,  carry_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q,   cout_d;
  logic          ovf_q,    ovf_d;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  // Select the current operand nibbles by index
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = opa_q[4*n +: 4];
        nib_b = opb_q[4*n +: 4];
      end
    end
  end

  // Drive the slice only while running; zeros otherwise
  always_comb begin
    alu_a_o   = 4'h0;
    alu_b_o   = 4'h0;
    alu_cin_o = 1'b0;
    if (state_q == S_RUN) begin
      alu_a_o   = nib_a;
      alu_b_o   = nib_b;
      alu_cin_o = carry_q;
    end
  end

  // Next-state logic: capture, nibble stepping, result assembly
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opa_d    = bus.op_a;
          // Subtraction as A + ~B + 1: invert B here, seed carry with 1
          opb_d    = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IW'(n)) begin
            result_d[4*n +: 4] = alu_s_i;
          end
        end
        carry_d = alu_cout_i;
        if (idx_q == IDX_LAST) begin
          cout_d  = alu_cout_i;
          // opb_q is already inverted for subtract, so one rule covers both
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (alu_s_i[3] != opa_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Scoreboard bench for the nibble-serial add/subtract controller with a
// behavioural 4-bit adder slice.
module tb_nibble_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_a, alu_b, alu_s;
  logic       alu_cin, alu_cout;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  exp_t sb[$];

  logic       cin_seen [NIBBLES];
  logic [3:0] b_seen   [NIBBLES];
  logic [W-1:0] last_exp;

  nibble_serial_addsub_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_cin_o  (alu_cin),
    .alu_s_i    (alu_s),
    .alu_cout_i (alu_cout)
  );

  // Behavioural add-only slice
  assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare completed operations against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("cout", 64'(bus.cout), 64'(e.c));
        chk("overflow", 64'(bus.overflow), 64'(e.v));
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W:0] sum;
    if (s) sum = {1'b0, a} - {1'b0, b} + {1'b0, {W{1'b1}}} + 1'b1;
    else   sum = {1'b0, a} + {1'b0, b};
    e.res = sum[W-1:0];
    e.c   = sum[W];
    if (s) e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    else   e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // mode 0: plain op, 1: stray start during RUN, 2: reset during RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int mode);
    exp_t e;
    int   k;
    int   d0;
    logic seen;
    e = model(a, b, s);
    last_exp = e.res;
    sb.push_back(e);
    for (int i = 0; i < NIBBLES; i++) begin
      cin_seen[i] = 1'bx;
      b_seen[i]   = 4'hx;
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sub = s; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sub = ~s; bus.op_a = W'($urandom); bus.op_b = W'($urandom);
    d0 = done_cnt;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else if (k <= NIBBLES) begin
        cin_seen[k-1] = alu_cin;
        b_seen[k-1]   = alu_b;
      end
      if (mode == 1 && k == 2) begin
        bus.start = 1'b1; bus.op_a = 16'h5555; bus.op_b = 16'h1111; bus.sub = 1'b0;
      end
      if (mode == 1 && k == 3) bus.start = 1'b0;
      if (mode == 2 && k == 3) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        rst_n = 1'b1;
        void'(sb.pop_back());
        repeat (8) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_idle", 64'(bus.busy), 64'd0);
        return;
      end
    end
    chk("timeout", 64'(seen), 64'd1);
    chk("latency", 64'(k), 64'(NIBBLES + 1));
    // Start coincident with done must be ignored
    bus.start = 1'b1; bus.op_a = 16'hAAAA; bus.op_b = 16'h0F0F;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("result_hold", 64'(bus.result), 64'(e.res));
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state_busy", 64'(bus.busy), 64'd0);
    chk("rst_state_done", 64'(bus.done), 64'd0);
    chk("rst_state_result", 64'(bus.result), 64'd0);
    chk("rst_state_cout", 64'(bus.cout), 64'd0);
    chk("rst_state_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_state_alu", 64'({alu_a, alu_b, alu_cin}), 64'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 0);
    chk("add_cin_n0", 64'(cin_seen[0]), 64'd0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    chk("ripple_cin_n1", 64'(cin_seen[1]), 64'd1);
    chk("ripple_cin_n2", 64'(cin_seen[2]), 64'd1);
    chk("ripple_cin_n3", 64'(cin_seen[3]), 64'd1);

    run_op(16'h0005, 16'h0003, 1'b1, 0);
    chk("sub_b_n0", 64'(b_seen[0]), 64'hC);
    chk("sub_cin_n0", 64'(cin_seen[0]), 64'd1);

    run_op(16'h0003, 16'h0005, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);

    run_op(16'h0F0F, 16'h00FF, 1'b0, 1);
    run_op(16'h4321, 16'h1111, 1'b1, 2);

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
